pipelined_instr_decoder: RTL and testbench

//  Registered, parametrised instruction decoder between fetch and register-read in the multicycle RISC core.

---
 rtl/decode_pkg.sv | 35 +++
 rtl/decode_fields.sv | 37 +++
 rtl/pipelined_instr_decoder.sv | 160 ++++++++++++++++
 tb/tb_pipelined_instr_decoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types for the pipelined instruction decoder: format codes, skid states, decoded payload.
// Widths here are the default build; the top module's parameters default to them.
package decode_pkg;

  localparam int P_INSTR_W = 16;
  localparam int P_OPC_W   = 4;
  localparam int P_RA_W    = 3;
  localparam int P_DATA_W  = 16;
  localparam int P_FW      = P_INSTR_W - P_OPC_W;
  localparam int P_IMM_W   = P_FW - 1 - 2 * P_RA_W;
  localparam int P_SIMM_W  = P_FW - P_RA_W - 1;

  typedef logic [1:0] fmt_t;

  localparam fmt_t FMT_R = 2'b00;
  localparam fmt_t FMT_I = 2'b01;
  localparam fmt_t FMT_J = 2'b10;
  localparam fmt_t FMT_S = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    fmt_t                fmt;
    logic [P_RA_W-1:0]   rd;
    logic [P_RA_W-1:0]   rs1;
    logic [P_RA_W-1:0]   rs2;
    logic                m;
    logic [P_DATA_W-1:0] imm;
  } payload_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational field extraction and sign-extension: low instruction bits + format -> payload.
// Fields a format does not use are driven to zero.
module decode_fields
  import decode_pkg::*;
(
  input  logic [P_FW-1:0] fw,
  input  fmt_t            func,
  output payload_t        dec
);

  always_comb begin
    dec     = '0;
    dec.fmt = func;
    case (func)
      FMT_R: begin
        dec.rd  = fw[P_FW-1 -: P_RA_W];
        dec.rs1 = fw[P_FW-1-P_RA_W -: P_RA_W];
        dec.rs2 = fw[P_FW-1-2*P_RA_W -: P_RA_W];
      end
      FMT_I: begin
        dec.m   = fw[P_FW-1];
        dec.rd  = fw[P_FW-2 -: P_RA_W];
        dec.rs1 = fw[P_FW-2-P_RA_W -: P_RA_W];
        dec.imm = {{(P_DATA_W-P_IMM_W){fw[P_IMM_W-1]}}, fw[P_IMM_W-1:0]};
      end
      FMT_J: begin
        dec.imm = {{(P_DATA_W-P_FW){fw[P_FW-1]}}, fw};
      end
      default: begin
        // S-format immediate skips bit 0
        dec.rs1 = fw[P_FW-1 -: P_RA_W];
        dec.imm = {{(P_DATA_W-P_SIMM_W){fw[P_SIMM_W]}}, fw[P_SIMM_W:1]};
      end
    endcase
  end

endmodule

// File: rtl/pipelined_instr_decoder.sv
// Registered instruction decoder with a 2-entry skid buffer between fetch and register-read.
// Optional RAW hazard tracker enabled by defining DECODE_HAZARD_EN.
module pipelined_instr_decoder
  import decode_pkg::*;
#(
  parameter int INSTR_W = P_INSTR_W,
  parameter int OPC_W   = P_OPC_W,
  parameter int RA_W    = P_RA_W,
  parameter int DATA_W  = P_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [1:0]         in_func,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_fmt,
  output logic [RA_W-1:0]    out_rd,
  output logic [RA_W-1:0]    out_rs1,
  output logic [RA_W-1:0]    out_rs2,
  output logic               out_m,
  output logic [DATA_W-1:0]  out_imm,
  output logic               out_raw
);

  localparam int FW = INSTR_W - OPC_W;

  // Handshake: a beat transfers on a cycle where valid and ready are both high; valid never
  // depends on ready, and the payload is held stable while valid is high and ready is low.
  skid_state_t state_q, state_d;
  logic        in_ready_q, in_ready_d;
  payload_t    main_q, main_d, skid_q, skid_d, dec;
  logic        acc, prod, ld_main_in, ld_main_skid, ld_skid;
  logic [OPC_W-1:0] unused_opc;

  assign unused_opc = in_instr[INSTR_W-1 -: OPC_W];

  decode_fields u_fields (
    .fw   (in_instr[FW-1:0]),
    .func (in_func),
    .dec  (dec)
  );

  always_comb begin
    acc          = in_valid & in_ready_q;
    prod         = (state_q != EMPTY) & out_ready;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    state_d      = state_q;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          ld_main_in = 1'b1;
          state_d    = HALF;
        end
      end
      HALF: begin
        if (acc && prod) begin
          ld_main_in = 1'b1;
        end else if (acc) begin
          ld_skid = 1'b1;
          state_d = FULL;
        end else if (prod) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (prod) begin
          ld_main_skid = 1'b1;
          state_d      = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      state_d      = EMPTY;
    end
    in_ready_d = (state_d != FULL);
    main_d     = ld_main_in ? dec : (ld_main_skid ? skid_q : main_q);
    skid_d     = ld_skid ? dec : skid_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_fmt   = main_q.fmt;
  assign out_rd    = main_q.rd;
  assign out_rs1   = main_q.rs1;
  assign out_rs2   = main_q.rs2;
  assign out_m     = main_q.m;
  assign out_imm   = main_q.imm;

`ifdef DECODE_HAZARD_EN
  logic            trk_v_q, trk_v_d, hit;
  logic [RA_W-1:0] trk_rd_q, trk_rd_d;
  logic            raw_main_q, raw_main_d, raw_skid_q, raw_skid_d;

  // The hazard flag is computed at accept time and travels with its beat through the skid buffer.
  always_comb begin
    case (dec.fmt)
      FMT_R:        hit = trk_v_q & ((dec.rs1 == trk_rd_q) | (dec.rs2 == trk_rd_q));
      FMT_I, FMT_S: hit = trk_v_q & (dec.rs1 == trk_rd_q);
      default:      hit = 1'b0;
    endcase
    trk_v_d  = trk_v_q;
    trk_rd_d = trk_rd_q;
    if (flush) begin
      trk_v_d  = 1'b0;
    end else if (acc) begin
      if (dec.fmt == FMT_R || dec.fmt == FMT_I) begin
        trk_v_d  = 1'b1;
        trk_rd_d = dec.rd;
      end else begin
        trk_v_d = 1'b0;
      end
    end
    raw_main_d = ld_main_in ? hit : (ld_main_skid ? raw_skid_q : raw_main_q);
    raw_skid_d = ld_skid ? hit : raw_skid_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trk_v_q    <= 1'b0;
      trk_rd_q   <= '0;
      raw_main_q <= 1'b0;
      raw_skid_q <= 1'b0;
    end else begin
      trk_v_q    <= trk_v_d;
      trk_rd_q   <= trk_rd_d;
      raw_main_q <= raw_main_d;
      raw_skid_q <= raw_skid_d;
    end
  end

  assign out_raw = raw_main_q;
`else
  assign out_raw = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_instr_decoder.sv
// Self-checking bench for pipelined_instr_decoder: directed vectors, stall/flush/reset cases,
// and a random stream checked against a reference decoder through an expected queue.
module tb_pipelined_instr_decoder;

  localparam int W = 29;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_m, out_raw;
  logic [15:0] in_instr, out_imm;
  logic [1:0]  in_func, out_fmt;
  logic [2:0]  out_rd, out_rs1, out_rs2;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_pops   = 0;
  logic         trk_v    = 1'b0;
  logic [2:0]   trk_rd   = 3'd0;
  logic         last_acc;

  always #5 clk = ~clk;

  pipelined_instr_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_func   (in_func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fmt   (out_fmt),
    .out_rd    (out_rd),
    .out_rs1   (out_rs1),
    .out_rs2   (out_rs2),
    .out_m     (out_m),
    .out_imm   (out_imm),
    .out_raw   (out_raw)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_dec(input logic [15:0] i, input logic [1:0] f,
                                           input logic raw);
    logic [2:0]  rd, rs1, rs2;
    logic        m;
    logic [15:0] imm;
    rd = 3'd0; rs1 = 3'd0; rs2 = 3'd0; m = 1'b0; imm = 16'd0;
    case (f)
      2'b00: begin rd = i[11:9]; rs1 = i[8:6]; rs2 = i[5:3]; end
      2'b01: begin m = i[11]; rd = i[10:8]; rs1 = i[7:5]; imm = {{11{i[4]}}, i[4:0]}; end
      2'b10: imm = {{4{i[11]}}, i[11:0]};
      default: begin rs1 = i[11:9]; imm = {{8{i[8]}}, i[8:1]}; end
    endcase
    return {f, rd, rs1, rs2, m, imm, raw};
  endfunction

  function automatic logic [W-1:0] obs_vec();
    return {out_fmt, out_rd, out_rs1, out_rs2, out_m, out_imm, out_raw};
  endfunction

  // One clock: sample at negedge, update scoreboard, return #1 after posedge.
  task automatic step();
    logic         prod, hit;
    logic [W-1:0] e;
    @(negedge clk);
    last_acc = in_valid && in_ready && !flush && !reset;
    prod     = out_valid && out_ready && !flush && !reset;
    if (prod) begin
      check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("sb_beat", 32'(obs_vec()), 32'(e));
        n_pops++;
      end
    end
    if (flush || reset) begin
      exp_q.delete();
      trk_v = 1'b0;
    end else if (last_acc) begin
      hit = 1'b0;
`ifdef DECODE_HAZARD_EN
      case (in_func)
        2'b00: hit = trk_v && (in_instr[8:6] == trk_rd || in_instr[5:3] == trk_rd);
        2'b01: hit = trk_v && (in_instr[7:5] == trk_rd);
        2'b11: hit = trk_v && (in_instr[11:9] == trk_rd);
        default: hit = 1'b0;
      endcase
`endif
      exp_q.push_back(ref_dec(in_instr, in_func, hit));
      if (in_func == 2'b00) begin trk_v = 1'b1; trk_rd = in_instr[11:9]; end
      else if (in_func == 2'b01) begin trk_v = 1'b1; trk_rd = in_instr[10:8]; end
      else trk_v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] i, input logic [1:0] f);
    int  n;
    logic ok;
    in_valid = 1'b1; in_instr = i; in_func = f;
    n = 0; ok = 1'b0;
    while (!ok && n < 10) begin
      step();
      ok = last_acc;
      n++;
    end
    check_val("accept_in_time", 32'(ok), 32'd1);
    in_valid = 1'b0;
  endtask

  logic [15:0] vec_i[3]   = '{16'h05FC, 16'h0800, 16'h0F3F};
  logic [1:0]  vec_f[3]   = '{2'b11, 2'b10, 2'b01};
  logic [15:0] vec_imm[3] = '{16'hFFFE, 16'hF800, 16'hFFFF};
  logic [15:0] beats[4]   = '{16'h0249, 16'h0492, 16'h06DB, 16'h0124};
  logic        raw_exp;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 16'd0; in_func = 2'b00;
`ifdef DECODE_HAZARD_EN
    raw_exp = 1'b1;
`else
    raw_exp = 1'b0;
`endif
    step(); step();
    reset = 1'b0;
    check_val("reset_out_valid", 32'(out_valid), 32'd0);
    check_val("reset_in_ready", 32'(in_ready), 32'd1);
    check_val("reset_payload", 32'(obs_vec()), 32'd0);

    // Directed R, then S/J/I at full rate
    out_ready = 1'b1;
    send(16'h0AC8, 2'b00);
    check_val("r_valid", 32'(out_valid), 32'd1);
    check_val("r_rd", 32'(out_rd), 32'd5);
    check_val("r_rs1", 32'(out_rs1), 32'd3);
    check_val("r_rs2", 32'(out_rs2), 32'd1);
    check_val("r_imm", 32'(out_imm), 32'd0);
    for (int k = 0; k < 3; k++) begin
      send(vec_i[k], vec_f[k]);
      check_val("fmt_imm", 32'(out_imm), 32'(vec_imm[k]));
    end
    check_val("i_m", 32'(out_m), 32'd1);
    check_val("i_rd", 32'(out_rd), 32'd7);
    check_val("i_rs1", 32'(out_rs1), 32'd1);
    step();

    // Stall with four queued beats, then drain
    begin
      int k, n, base;
      out_ready = 1'b0; k = 0;
      for (int c = 0; c < 6; c++) begin
        in_valid = (k < 4); in_instr = beats[k % 4]; in_func = 2'b00;
        step();
        if (last_acc) k++;
      end
      check_val("stall_accepted", 32'(k), 32'd2);
      check_val("stall_in_ready", 32'(in_ready), 32'd0);
      check_val("stall_hold_rd", 32'(out_rd), 32'(beats[0][11:9]));
      check_val("stall_hold_rs2", 32'(out_rs2), 32'(beats[0][5:3]));
      out_ready = 1'b1; base = n_pops; n = 0;
      while ((k < 4 || exp_q.size() != 0) && n < 20) begin
        in_valid = (k < 4); in_instr = beats[k % 4]; in_func = 2'b00;
        step();
        if (last_acc) k++;
        n++;
      end
      in_valid = 1'b0;
      check_val("drain_pops", 32'(n_pops - base), 32'd4);
      check_val("drain_empty", 32'(exp_q.size()), 32'd0);
    end

    // Flush from FULL with a beat offered
    out_ready = 1'b0;
    send(16'h0111, 2'b00);
    send(16'h0222, 2'b01);
    check_val("full_in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 16'h0FFF; in_func = 2'b10;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush_out_valid", 32'(out_valid), 32'd0);
    check_val("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step(); step(); step();
    check_val("flush_stays_empty", 32'(out_valid), 32'd0);

    // Reset from FULL
    out_ready = 1'b0;
    send(16'h0333, 2'b11);
    send(16'h0444, 2'b01);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_payload", 32'(obs_vec()), 32'd0);

    // Hazard: R rd=5 then R rs2=5; then with a J in between
    out_ready = 1'b1;
    send(16'h0AC8, 2'b00);
    send(16'h0028, 2'b00);
    check_val("raw_hit", 32'(out_raw), 32'(raw_exp));
    send(16'h0AC8, 2'b00);
    send(16'h0000, 2'b10);
    send(16'h0028, 2'b00);
    check_val("raw_after_j", 32'(out_raw), 32'd0);
    step();

    // Random stream with random backpressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_instr  = 16'($urandom_range(0, 16'hFFFF));
      in_func   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();
    check_val("final_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
